// File: rtl/prbs_check_mc.sv
// prbs_check_mc: multi-lane PRBS-31 (x^31+x^28+1) link checker with per-lane lock FSM and saturating error counters
//   CLK        clock
//   RSTX       synchronous active-low reset
//   INIT       restart all lanes (IDLE, counters cleared)
//   CLR        clear all error counters, lock state kept
//   DIN        NCH*BW lane words, lane i at DIN[i*BW +: BW], bit BW-1 earliest
//   DIPUSH     per-lane word valid
//   ALIGNED    per-lane word alignment achieved
//   LOCKED     per-lane lock indication
//   ERR_CNT    NCH*CW saturating error counters, lane i at ERR_CNT[i*CW +: CW]
//   ERR_PULSE  per-lane one-cycle error pulse
// Optional macro BIT_ERR_CNT_EN: count bit errors (pipelined popcount) instead of word errors.
module prbs_check_mc #(
  parameter int BW       = 64,
  parameter int NCH      = 2,
  parameter int CW       = 8,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 4
) (
  input  logic                CLK,
  input  logic                RSTX,
  input  logic                INIT,
  input  logic                CLR,
  input  logic [NCH*BW-1:0]   DIN,
  input  logic [NCH-1:0]      DIPUSH,
  input  logic [NCH-1:0]      ALIGNED,
  output logic [NCH-1:0]      LOCKED,
  output logic [NCH*CW-1:0]   ERR_CNT,
  output logic [NCH-1:0]      ERR_PULSE
);
  typedef enum logic [1:0] {IDLE, SEARCH, LOCK} state_t;
  // Unrolls the recurrence: bits above BW hold the 31-bit state, each lower bit
  // is generated from the bits 31 and 28 positions earlier.
  function automatic logic [BW-1:0] predict(input logic [30:0] st);
    logic [BW+30:0] e;
    e = '0;
    e[BW+30:BW] = st;
    for (int j = BW-1; j >= 0; j--) e[j] = e[j+31] ^ e[j+28];
    return e[BW-1:0];
  endfunction
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    state_t         st_q, st_d;
    logic [30:0]    prbs_q, prbs_d;
    logic           seed_q, seed_d;
    logic [7:0]     good_q, good_d, bad_q, bad_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           locked_q, pulse_q;
    logic [BW-1:0]  din, pred;
    logic           match, err;
    assign din   = DIN[i*BW +: BW];
    assign pred  = predict(prbs_q);
    assign match = din == pred;
    always_ff @(posedge CLK) begin
      if (!RSTX) begin
        st_q     <= IDLE;
        prbs_q   <= '0;
        seed_q   <= 1'b1;
        good_q   <= '0;
        bad_q    <= '0;
        cnt_q    <= '0;
        locked_q <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        st_q     <= st_d;
        prbs_q   <= prbs_d;
        seed_q   <= seed_d;
        good_q   <= good_d;
        bad_q    <= bad_d;
        cnt_q    <= cnt_d;
        locked_q <= st_d == LOCK;
        pulse_q  <= err;
      end
    end
    always_comb begin
      st_d = st_q;
      if (INIT || !ALIGNED[i]) st_d = IDLE;
      else if (st_q == IDLE) st_d = SEARCH;
      else if (DIPUSH[i] && st_q == SEARCH && !seed_q && match && good_q == 8'(LOCK_N-1)) st_d = LOCK;
      else if (DIPUSH[i] && st_q == LOCK && !match && bad_q == 8'(UNLOCK_N-1)) st_d = SEARCH;
    end
    // In SEARCH the state follows the received data; in LOCK it free-runs so a
    // single corrupted word does not poison the following predictions.
    always_comb begin
      prbs_d = prbs_q;
      seed_d = seed_q;
      good_d = good_q;
      bad_d  = bad_q;
      err    = 1'b0;
      if (st_d == IDLE) begin
        {seed_d, good_d, bad_d} = {1'b1, 16'd0};
      end else if (DIPUSH[i] && st_q == SEARCH) begin
        prbs_d = din[30:0];
        seed_d = 1'b0;
        good_d = (seed_q || !match) ? 8'd0 : good_q + 8'd1;
        bad_d  = st_d == LOCK ? 8'd0 : bad_q;
      end else if (DIPUSH[i] && st_q == LOCK) begin
        prbs_d = pred[30:0];
        err    = !match;
        bad_d  = match ? 8'd0 : bad_q + 8'd1;
        if (st_d == SEARCH) {seed_d, good_d, bad_d} = {1'b1, 16'd0};
      end
    end
`ifdef BIT_ERR_CNT_EN
    localparam int PW = $clog2(BW+1);
    localparam int SW = CW + PW + 1;
    logic [PW-1:0] pc, pc_q;
    logic          pcv_q;
    logic [SW-1:0] sum;
    always_comb begin
      pc = '0;
      for (int b = 0; b < BW; b++) pc = pc + PW'(din[b] ^ pred[b]);
    end
    // An error seen together with CLR is dropped before it reaches the counter.
    always_ff @(posedge CLK) begin
      if (!RSTX) begin
        pc_q  <= '0;
        pcv_q <= 1'b0;
      end else begin
        pc_q  <= pc;
        pcv_q <= err && !CLR;
      end
    end
    assign sum   = SW'(cnt_q) + SW'(pc_q);
    assign cnt_d = (INIT || CLR) ? '0 : !pcv_q ? cnt_q : (sum > SW'({CW{1'b1}})) ? '1 : sum[CW-1:0];
`else
    assign cnt_d = (INIT || CLR) ? '0 : (err && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
`endif
    assign LOCKED[i]           = locked_q;
    assign ERR_PULSE[i]        = pulse_q;
    assign ERR_CNT[i*CW +: CW] = cnt_q;
  end
endmodule

// File: tb/tb_prbs_check_mc.sv
// tb_prbs_check_mc: directed bench for prbs_check_mc with a bit-serial PRBS-31 reference source
module tb_prbs_check_mc;
  localparam int BW  = 64;
  localparam int NCH = 2;
  localparam int CW  = 4;
  logic              CLK = 1'b0;
  logic              RSTX = 1'b0;
  logic              INIT = 1'b0;
  logic              CLR = 1'b0;
  logic [NCH*BW-1:0] DIN = '0;
  logic [NCH-1:0]    DIPUSH = '0;
  logic [NCH-1:0]    ALIGNED = '0;
  logic [NCH-1:0]    LOCKED;
  logic [NCH*CW-1:0] ERR_CNT;
  logic [NCH-1:0]    ERR_PULSE;
  int nvec = 0;
  int nerr = 0;
  logic [30:0] h [NCH];
  prbs_check_mc #(.BW(BW), .NCH(NCH), .CW(CW), .LOCK_N(4), .UNLOCK_N(4)) dut (
    .CLK(CLK), .RSTX(RSTX), .INIT(INIT), .CLR(CLR), .DIN(DIN), .DIPUSH(DIPUSH),
    .ALIGNED(ALIGNED), .LOCKED(LOCKED), .ERR_CNT(ERR_CNT), .ERR_PULSE(ERR_PULSE)
  );
  always #5 CLK = ~CLK;
  task automatic gen_word(input int l, output logic [BW-1:0] w);
    logic nb;
    for (int b = BW-1; b >= 0; b--) begin
      nb = h[l][30] ^ h[l][27];
      h[l] = {h[l][29:0], nb};
      w[b] = nb;
    end
  endtask
  task automatic push(input logic [NCH-1:0] v, input logic [BW-1:0] f0);
    logic [BW-1:0] w;
    for (int l = 0; l < NCH; l++) begin
      if (v[l]) begin
        gen_word(l, w);
        if (l == 0) w = w ^ f0;
        DIN[l*BW +: BW] = w;
      end
    end
    DIPUSH = v;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    RSTX = 1'b0;
    ALIGNED = 2'b11;
    DIPUSH = 2'b11;
    DIN = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge CLK);
    #1;
    nvec++;
    if (LOCKED !== 2'b00 || ERR_CNT !== '0 || ERR_PULSE !== 2'b00) begin
      nerr++;
      $display("FAIL reset: LOCKED=%b ERR_CNT=%h ERR_PULSE=%b, required 00/00/00", LOCKED, ERR_CNT, ERR_PULSE);
    end
    RSTX = 1'b1;
    push(2'b00, '0);
    nvec++;
    if (LOCKED !== 2'b00) begin
      nerr++;
      $display("FAIL reset_release: LOCKED=%b required 00", LOCKED);
    end
  endtask
  task automatic test_lock();
    for (int k = 1; k <= 5; k++) begin
      push(2'b11, '0);
      nvec++;
      if (LOCKED !== (k == 5 ? 2'b11 : 2'b00)) begin
        nerr++;
        $display("FAIL lock word %0d: LOCKED=%b required %b", k, LOCKED, k == 5 ? 2'b11 : 2'b00);
      end
    end
    for (int k = 0; k < 1000; k++) begin
      push(2'b11, '0);
      nvec++;
      if (LOCKED !== 2'b11 || ERR_CNT !== '0 || ERR_PULSE !== 2'b00) begin
        nerr++;
        $display("FAIL clean word %0d: LOCKED=%b ERR_CNT=%h ERR_PULSE=%b, required 11/00/00", k, LOCKED, ERR_CNT, ERR_PULSE);
      end
    end
  endtask
  task automatic test_bit_flip();
    push(2'b11, 64'h0000_0100_0010_0001);
    nvec++;
    if (ERR_CNT !== 8'h01 || ERR_PULSE !== 2'b01 || LOCKED !== 2'b11) begin
      nerr++;
      $display("FAIL bit_flip: ERR_CNT=%h ERR_PULSE=%b LOCKED=%b, required 01/01/11", ERR_CNT, ERR_PULSE, LOCKED);
    end
    push(2'b11, '0);
    nvec++;
    if (ERR_CNT !== 8'h01 || ERR_PULSE !== 2'b00 || LOCKED !== 2'b11) begin
      nerr++;
      $display("FAIL bit_flip_after: ERR_CNT=%h ERR_PULSE=%b LOCKED=%b, required 01/00/11", ERR_CNT, ERR_PULSE, LOCKED);
    end
  endtask
  task automatic test_unlock();
    CLR = 1'b1;
    push(2'b11, '0);
    CLR = 1'b0;
    nvec++;
    if (ERR_CNT !== 8'h00 || LOCKED !== 2'b11) begin
      nerr++;
      $display("FAIL clr: ERR_CNT=%h LOCKED=%b, required 00/11", ERR_CNT, LOCKED);
    end
    for (int k = 1; k <= 4; k++) begin
      push(2'b11, 64'h8000_0000_0000_0001 << k);
      nvec++;
      if (ERR_CNT[3:0] !== 4'(k) || LOCKED !== (k == 4 ? 2'b10 : 2'b11)) begin
        nerr++;
        $display("FAIL unlock word %0d: cnt0=%0d LOCKED=%b, required %0d/%b", k, ERR_CNT[3:0], LOCKED, k, k == 4 ? 2'b10 : 2'b11);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      push(2'b11, '0);
      nvec++;
      if (LOCKED !== (k == 5 ? 2'b11 : 2'b10) || ERR_CNT !== 8'h04) begin
        nerr++;
        $display("FAIL relock word %0d: LOCKED=%b ERR_CNT=%h, required %b/04", k, LOCKED, ERR_CNT, k == 5 ? 2'b11 : 2'b10);
      end
    end
  endtask
  task automatic test_saturate();
    int e = 4;
    for (int k = 0; k < 20; k++) begin
      push(2'b11, 64'h1 << (k % 64));
      e = e < 15 ? e + 1 : 15;
      nvec++;
      if (ERR_CNT[3:0] !== 4'(e) || ERR_PULSE !== 2'b01 || LOCKED !== 2'b11) begin
        nerr++;
        $display("FAIL saturate err %0d: cnt0=%0d pulse=%b LOCKED=%b, required %0d/01/11", k, ERR_CNT[3:0], ERR_PULSE, LOCKED, e);
      end
      push(2'b11, '0);
    end
    CLR = 1'b1;
    push(2'b11, 64'h10);
    CLR = 1'b0;
    nvec++;
    if (ERR_CNT !== 8'h00 || ERR_PULSE !== 2'b01 || LOCKED !== 2'b11) begin
      nerr++;
      $display("FAIL clr_with_err: ERR_CNT=%h pulse=%b LOCKED=%b, required 00/01/11", ERR_CNT, ERR_PULSE, LOCKED);
    end
    push(2'b11, '0);
  endtask
  task automatic test_align();
    ALIGNED = 2'b01;
    push(2'b11, '0);
    nvec++;
    if (LOCKED !== 2'b01) begin
      nerr++;
      $display("FAIL align_drop: LOCKED=%b required 01", LOCKED);
    end
    ALIGNED = 2'b11;
    push(2'b11, '0);
    for (int k = 1; k <= 5; k++) begin
      push(2'b11, '0);
      nvec++;
      if (LOCKED !== (k == 5 ? 2'b11 : 2'b01) || ERR_CNT !== 8'h00) begin
        nerr++;
        $display("FAIL align_relock word %0d: LOCKED=%b ERR_CNT=%h, required %b/00", k, LOCKED, ERR_CNT, k == 5 ? 2'b11 : 2'b01);
      end
    end
  endtask
  task automatic test_init();
    push(2'b11, 64'h4);
    INIT = 1'b1;
    push(2'b11, 64'h4);
    INIT = 1'b0;
    nvec++;
    if (LOCKED !== 2'b00 || ERR_CNT !== '0 || ERR_PULSE !== 2'b00) begin
      nerr++;
      $display("FAIL init: LOCKED=%b ERR_CNT=%h pulse=%b, required 00/00/00", LOCKED, ERR_CNT, ERR_PULSE);
    end
    push(2'b11, '0);
    for (int k = 1; k <= 5; k++) begin
      push(2'b11, '0);
      nvec++;
      if (LOCKED !== (k == 5 ? 2'b11 : 2'b00)) begin
        nerr++;
        $display("FAIL init_relock word %0d: LOCKED=%b required %b", k, LOCKED, k == 5 ? 2'b11 : 2'b00);
      end
    end
  endtask
  task automatic test_gaps();
    for (int k = 0; k < 300; k++) begin
      push(2'($urandom_range(0, 3)), '0);
      nvec++;
      if (LOCKED !== 2'b11 || ERR_PULSE !== 2'b00 || ERR_CNT !== '0) begin
        nerr++;
        $display("FAIL gaps cycle %0d: LOCKED=%b pulse=%b ERR_CNT=%h, required 11/00/00", k, LOCKED, ERR_PULSE, ERR_CNT);
      end
    end
  endtask
  initial begin
    h[0] = 31'h0123_4567;
    h[1] = 31'h7654_3210;
    test_reset();
    test_lock();
    test_bit_flip();
    test_unlock();
    test_saturate();
    test_align();
    test_init();
    test_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
